// File: rtl/axi_io_bridge.sv
// axi_io_bridge: AXI-lite style request port to a strobe/ready IO bus.
// Requests are registered and held stable for the whole IO transaction.
// Simultaneous read/write requests are arbitrated round-robin.
// Responses are single-cycle pulses.
// Optional feature macro: IO_TIMEOUT_EN enables a bus timeout that forces an
// error completion after TIMEOUT cycles in ISSUE+WAIT.
module axi_io_bridge #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write request / response
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  bvalid,
    output logic                  berr,
    // read request / response
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_W-1:0]     araddr,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rerr,
    // IO bus
    output logic                  io_addr_strobe,
    output logic                  io_read_strobe,
    output logic                  io_write_strobe,
    output logic [ADDR_W-1:0]     io_addr,
    output logic [DATA_W/8-1:0]   io_byte_enable,
    output logic [DATA_W-1:0]     io_write_data,
    input  logic [DATA_W-1:0]     io_read_data,
    input  logic                  io_ready
);

    localparam int unsigned         STRB_W    = DATA_W / 8;
    localparam logic [DATA_W-1:0]   ERR_RDATA = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                op_write_q, op_write_d;
    logic [ADDR_W-1:0]   io_addr_q, io_addr_d;
    logic [STRB_W-1:0]   io_be_q, io_be_d;
    logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;
    logic                io_rd_stb_q, io_rd_stb_d;
    logic                io_wr_stb_q, io_wr_stb_d;
    logic                io_as_q, io_as_d;
    logic                bvalid_q, bvalid_d;
    logic                rvalid_q, rvalid_d;
    logic                berr_q, berr_d;
    logic                rerr_q, rerr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                grant_w;
    logic                grant_r;
    logic                timeout_hit;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Transaction age counter: cleared on accept, counts ISSUE and WAIT cycles
    always_comb begin
        cnt_d = cnt_q;
        if (grant_w || grant_r) begin
            cnt_d = '0;
        end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == TO_LAST);
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT;
    assign timeout_hit        = 1'b0;
`endif

    // Round-robin arbitration; only meaningful while IDLE
    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (state_q == S_IDLE) begin
            if (wvalid && arvalid) begin
                grant_w = (last_grant_q == GRANT_READ);
                grant_r = (last_grant_q == GRANT_WRITE);
            end else begin
                grant_w = wvalid;
                grant_r = arvalid;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        io_addr_d    = io_addr_q;
        io_be_d      = io_be_q;
        io_wdata_d   = io_wdata_q;
        rdata_d      = rdata_q;
        io_rd_stb_d  = 1'b0;
        io_wr_stb_d  = 1'b0;
        io_as_d      = 1'b0;
        bvalid_d     = 1'b0;
        rvalid_d     = 1'b0;
        berr_d       = 1'b0;
        rerr_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_w || grant_r) begin
                    state_d     = S_ISSUE;
                    op_write_d  = grant_w;
                    io_addr_d   = grant_w ? awaddr : araddr;
                    io_be_d     = grant_w ? wstrb : '1;
                    if (grant_w) begin
                        io_wdata_d = wdata;
                    end
                    io_wr_stb_d = grant_w;
                    io_rd_stb_d = grant_r;
                    io_as_d     = 1'b1;
                    if (wvalid && arvalid) begin
                        last_grant_d = grant_w ? GRANT_WRITE : GRANT_READ;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                // io_ready on the timeout cycle takes precedence: normal completion
                if (io_ready || timeout_hit) begin
                    state_d  = S_IDLE;
                    bvalid_d = op_write_q;
                    rvalid_d = !op_write_q;
                    berr_d   = op_write_q && !io_ready;
                    rerr_d   = !op_write_q && !io_ready;
                    if (!op_write_q) begin
                        rdata_d = io_ready ? io_read_data : ERR_RDATA;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_READ;
            op_write_q   <= 1'b0;
            io_addr_q    <= '0;
            io_be_q      <= '0;
            io_wdata_q   <= '0;
            io_rd_stb_q  <= 1'b0;
            io_wr_stb_q  <= 1'b0;
            io_as_q      <= 1'b0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            berr_q       <= 1'b0;
            rerr_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            io_addr_q    <= io_addr_d;
            io_be_q      <= io_be_d;
            io_wdata_q   <= io_wdata_d;
            io_rd_stb_q  <= io_rd_stb_d;
            io_wr_stb_q  <= io_wr_stb_d;
            io_as_q      <= io_as_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            berr_q       <= berr_d;
            rerr_q       <= rerr_d;
            rdata_q      <= rdata_d;
        end
    end

    assign wready          = grant_w;
    assign arready         = grant_r;
    assign bvalid          = bvalid_q;
    assign berr            = berr_q;
    assign rvalid          = rvalid_q;
    assign rerr            = rerr_q;
    assign rdata           = rdata_q;
    assign io_addr_strobe  = io_as_q;
    assign io_read_strobe  = io_rd_stb_q;
    assign io_write_strobe = io_wr_stb_q;
    assign io_addr         = io_addr_q;
    assign io_byte_enable  = io_be_q;
    assign io_write_data   = io_wdata_q;

endmodule

// File: tb/tb_axi_io_bridge.sv
// Directed testbench for axi_io_bridge (covers IO_TIMEOUT_EN when defined).
module tb_axi_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wvalid, wready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        bvalid, berr;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rerr;
    logic [31:0] rdata;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0] io_addr, io_write_data, io_read_data;
    logic [3:0]  io_byte_enable;
    logic        io_ready;

    int tests = 0;
    int fails = 0;
    int n_wr_stb = 0;
    int n_rd_stb = 0;

    axi_io_bridge #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (8),
        .ERR_DATA (32'hFFFF_FFFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wvalid          (wvalid),
        .wready          (wready),
        .awaddr          (awaddr),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .bvalid          (bvalid),
        .berr            (berr),
        .arvalid         (arvalid),
        .arready         (arready),
        .araddr          (araddr),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .rerr            (rerr),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_addr         (io_addr),
        .io_byte_enable  (io_byte_enable),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; wvalid = 1'b0; arvalid = 1'b0; io_ready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; io_read_data = '0;
        step(); step();
        rst_n = 1'b1;
        #1;
        // reset state
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_be", io_byte_enable, 0);
        chk("rst_rdata", rdata, 0);

        // single write, io_ready in ISSUE
        wvalid = 1'b1; awaddr = 32'h10; wdata = 32'hA5A5A5A5; wstrb = 4'h3;
        #1;
        chk("w1_wready", wready, 1);
        chk("w1_arready", arready, 0);
        step();
        wvalid = 1'b0; io_ready = 1'b1;
        #1;
        chk("w1_wstb", io_write_strobe, 1);
        chk("w1_rstb", io_read_strobe, 0);
        chk("w1_astb", io_addr_strobe, 1);
        chk("w1_addr", io_addr, 32'h10);
        chk("w1_be", io_byte_enable, 4'h3);
        chk("w1_wdata", io_write_data, 32'hA5A5A5A5);
        chk("w1_bvalid_early", bvalid, 0);
        step();
        io_ready = 1'b0;
        chk("w1_bvalid", bvalid, 1);
        chk("w1_berr", berr, 0);
        chk("w1_wstb_off", io_write_strobe, 0);
        step();
        chk("w1_bvalid_off", bvalid, 0);

        // read with 5 WAIT cycles
        arvalid = 1'b1; araddr = 32'h20;
        #1;
        chk("r1_arready", arready, 1);
        step();
        arvalid = 1'b0;
        chk("r1_rstb", io_read_strobe, 1);
        chk("r1_wstb", io_write_strobe, 0);
        chk("r1_be", io_byte_enable, 4'hF);
        chk("r1_addr_issue", io_addr, 32'h20);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r1_addr_wait", io_addr, 32'h20);
            chk("r1_rstb_wait", io_read_strobe, 0);
            chk("r1_rvalid_wait", rvalid, 0);
            if (i == 4) begin
                io_ready = 1'b1; io_read_data = 32'h12345678;
            end
        end
        step();
        io_ready = 1'b0; io_read_data = '0;
        chk("r1_rvalid", rvalid, 1);
        chk("r1_rdata", rdata, 32'h12345678);
        chk("r1_rerr", rerr, 0);
        step();
        chk("r1_rvalid_off", rvalid, 0);
        chk("r1_rdata_hold", rdata, 32'h12345678);

        // simultaneous requests from reset: W,R,W,R
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        awaddr = 32'h100; araddr = 32'h200; wdata = 32'h0; wstrb = 4'hF;
        wvalid = 1'b1; arvalid = 1'b1; io_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_w;
            exp_w = (i % 2 == 0);
            chk("arb_wready", wready, exp_w);
            chk("arb_arready", arready, !exp_w);
            step();
            chk("arb_wstb", io_write_strobe, exp_w);
            chk("arb_rstb", io_read_strobe, !exp_w);
            chk("arb_addr", io_addr, exp_w ? 32'h100 : 32'h200);
            if (io_write_strobe) n_wr_stb++;
            if (io_read_strobe) n_rd_stb++;
            if (i == 3) begin
                wvalid = 1'b0; arvalid = 1'b0;
            end
            step();
            chk("arb_bvalid", bvalid, exp_w);
            chk("arb_rvalid", rvalid, !exp_w);
        end
        io_ready = 1'b0;
        chk("arb_n_wr", n_wr_stb, 2);
        chk("arb_n_rd", n_rd_stb, 2);
        step();

`ifdef IO_TIMEOUT_EN
        // timeout: io_ready never asserted
        arvalid = 1'b1; araddr = 32'h30; io_read_data = 32'h55;
        step();
        arvalid = 1'b0;
        chk("to1_rstb", io_read_strobe, 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("to1_rvalid_wait", rvalid, 0);
        end
        step();
        chk("to1_rvalid", rvalid, 1);
        chk("to1_rerr", rerr, 1);
        chk("to1_rdata", rdata, 32'hFFFFFFFF);
        step();
        chk("to1_rvalid_off", rvalid, 0);
        // io_ready on the timeout cycle wins
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("to2_rvalid_wait", rvalid, 0);
        end
        io_ready = 1'b1; io_read_data = 32'hCAFEF00D;
        step();
        io_ready = 1'b0;
        chk("to2_rvalid", rvalid, 1);
        chk("to2_rerr", rerr, 0);
        chk("to2_rdata", rdata, 32'hCAFEF00D);
        step();
`else
        // without timeout, WAIT lasts until io_ready
        arvalid = 1'b1; araddr = 32'h30;
        step();
        arvalid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("nto_rvalid_wait", rvalid, 0);
        end
        io_ready = 1'b1; io_read_data = 32'h0BADBEEF;
        step();
        io_ready = 1'b0;
        chk("nto_rvalid", rvalid, 1);
        chk("nto_rerr", rerr, 0);
        chk("nto_rdata", rdata, 32'h0BADBEEF);
        step();
`endif

        // reset during WAIT of a write
        wvalid = 1'b1; awaddr = 32'h40; wdata = 32'h11; wstrb = 4'h1;
        step();
        wvalid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_bvalid", bvalid, 0);
        chk("rw_io_addr", io_addr, 0);
        step();
        chk("rw_bvalid2", bvalid, 0);
        wvalid = 1'b1; awaddr = 32'h44; wdata = 32'h22; wstrb = 4'hC;
        #1;
        chk("rw_wready", wready, 1);
        step();
        wvalid = 1'b0; io_ready = 1'b1;
        chk("rw_wstb", io_write_strobe, 1);
        chk("rw_addr", io_addr, 32'h44);
        chk("rw_be", io_byte_enable, 4'hC);
        step();
        io_ready = 1'b0;
        chk("rw_bvalid3", bvalid, 1);
        chk("rw_berr", berr, 0);
        step();

        // io_ready while IDLE is ignored
        io_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 0);
            chk("idle_resp", {bvalid, rvalid}, 0);
        end
        io_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
